uart_receiver: RTL and testbench

- Serial-to-parallel UART receive stage for the CPU's UART link: 8N1, LSB first, 16x oversampled.
- Directly upstream of the UART byte-protocol controller. Delivers each received byte on rx_data with a one-cycle rx_status strobe, which the controller edge-detects.
- Clocked from the CPU system clock; generates its own oversample tick.

---
 rtl/uart_receiver.sv | 209 ++++++++++++++++++++
 tb/tb_uart_receiver.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled UART receive stage, 8N1 by default, 8E1 when the
// UART_RX_PARITY_EN macro is defined. Good bytes land on rx_data with a one-cycle rx_status strobe.
module uart_receiver #(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_status,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);

    localparam logic [TW-1:0] TCNT_LAST = TW'(DIV - 1);
    localparam logic [SW-1:0] SCNT_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] SCNT_MID  = SW'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;

    state_t          state_q, state_n;
    logic            sync_q, rx_s;
    logic [TW-1:0]   tcnt_q, tcnt_n;
    logic [SW-1:0]   scnt_q, scnt_n;
    logic [2:0]      bcnt_q, bcnt_n;
    logic [7:0]      shift_q, shift_n;
    logic [7:0]      data_n;
    logic            status_n, ferr_n, perr_n;
    logic            tick;
`ifdef UART_RX_PARITY_EN
    logic            par_q, par_n;
`endif

    // Two-flop synchronizer; idles high so reset never looks like a start edge.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            sync_q <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make both flops sample pre-edge values, so this
            // stays a true two-stage chain regardless of statement order.
            sync_q <= uart_rx;
            rx_s   <= sync_q;
        end
    end

    assign tick = (tcnt_q == TCNT_LAST);
    assign busy = (state_q != IDLE);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path through the case
        // can leave one unassigned and infer a latch.
        state_n  = state_q;
        tcnt_n   = tick ? '0 : tcnt_q + TW'(1);
        scnt_n   = scnt_q;
        bcnt_n   = bcnt_q;
        shift_n  = shift_q;
        data_n   = rx_data;
        status_n = 1'b0;
        ferr_n   = 1'b0;
        perr_n   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_n    = par_q;
`endif

        case (state_q)
            IDLE: begin
                // Holding the divider at zero aligns every later tick to the start edge.
                tcnt_n = '0;
                scnt_n = '0;
                if (!rx_s) begin
                    state_n = START;
                end
            end

            START: begin
                if (tick) begin
                    if (scnt_q == SCNT_MID) begin
                        if (rx_s) begin
                            state_n = IDLE;
                        end else begin
                            state_n = DATA;
                            scnt_n  = '0;
                            bcnt_n  = '0;
                        end
                    end else begin
                        scnt_n = scnt_q + SW'(1);
                    end
                end
            end

            DATA: begin
                if (tick) begin
                    if (scnt_q == SCNT_LAST) begin
                        shift_n = {rx_s, shift_q[7:1]};
                        scnt_n  = '0;
                        if (bcnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end else begin
                            bcnt_n = bcnt_q + 3'd1;
                        end
                    end else begin
                        scnt_n = scnt_q + SW'(1);
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (scnt_q == SCNT_LAST) begin
                        par_n   = rx_s;
                        scnt_n  = '0;
                        state_n = STOP;
                    end else begin
                        scnt_n = scnt_q + SW'(1);
                    end
                end
            end
`endif

            STOP: begin
                if (tick) begin
                    if (scnt_q == SCNT_LAST) begin
                        scnt_n = '0;
                        if (!rx_s) begin
                            ferr_n  = 1'b1;
                            state_n = WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
                        end else if (^{shift_q, par_q}) begin
                            perr_n  = 1'b1;
                            state_n = IDLE;
`endif
                        end else begin
                            status_n = 1'b1;
                            data_n   = shift_q;
                            state_n  = IDLE;
                        end
                    end else begin
                        scnt_n = scnt_q + SW'(1);
                    end
                end
            end

            WAIT_HIGH: begin
                // A held-low line (break) reports once, then waits for idle.
                tcnt_n = '0;
                if (rx_s) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            tcnt_q     <= '0;
            scnt_q     <= '0;
            bcnt_q     <= '0;
            shift_q    <= '0;
            rx_data    <= 8'h00;
            rx_status  <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_n;
            tcnt_q     <= tcnt_n;
            scnt_q     <= scnt_n;
            bcnt_q     <= bcnt_n;
            shift_q    <= shift_n;
            rx_data    <= data_n;
            rx_status  <= status_n;
            frame_err  <= ferr_n;
            parity_err <= perr_n;
`ifdef UART_RX_PARITY_EN
            par_q      <= par_n;
`endif
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: directed and randomized frames checked every cycle against a
// frame-level model of the expected strobes and held byte. Follows UART_RX_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_receiver;

    localparam int CLK_HZ = 1600;
    localparam int BAUD   = 100;
    localparam int OS     = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS  = 9;
    localparam bit PAR_EN = 1'b1;
`else
    localparam int NBITS  = 8;
    localparam bit PAR_EN = 1'b0;
`endif
    // Start driven after edge k: 2 sync cycles, half a bit to the start midpoint,
    // NBITS+1 bit times to the stop midpoint, then the registered strobe.
    localparam int LATENCY = 2 + OS / 2 + (NBITS + 1) * OS + 1;

    logic       sysclk  = 1'b0;
    logic       reset   = 1'b1;
    logic       uart_rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_status, frame_err, parity_err, busy;

    uart_receiver #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OS)
    ) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .rx_data   (rx_data),
        .rx_status (rx_status),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .busy      (busy)
    );

    always #5 sysclk = ~sysclk;

    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    typedef enum int {EV_GOOD, EV_FERR, EV_PERR} ev_kind_t;
    typedef struct {
        int         cyc;
        ev_kind_t   kind;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] got_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_status = 0;
    int         n_ferr   = 0;
    int         n_perr   = 0;
    int         last_status_cyc = -1;
    logic [7:0] model_data = 8'h00;
    bit         checking = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic ev_kind_t frame_kind(input logic [7:0] d, input logic stop_b,
                                            input logic par_b);
        if (!stop_b) return EV_FERR;
        if (PAR_EN && ((^d) != par_b)) return EV_PERR;
        return EV_GOOD;
    endfunction

    // Inputs change 1 ns after a rising edge; tasks leave the bench in that phase.
    task automatic wait_cycles(input int n);
        if (n > 0) begin
            repeat (n) @(posedge sysclk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b,
                              output int k);
        ev_t ev;
        k       = cyc;
        ev.cyc  = k + LATENCY;
        ev.kind = frame_kind(d, stop_b, par_b);
        ev.data = d;
        exp_q.push_back(ev);
        uart_rx = 1'b0;
        wait_cycles(OS);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            wait_cycles(OS);
        end
        if (PAR_EN) begin
            uart_rx = par_b;
            wait_cycles(OS);
        end
        uart_rx = stop_b;
        wait_cycles(OS);
    endtask

    always @(negedge sysclk) begin : compare
        logic es, ef, ep;
        ev_t  ev;
        if (checking) begin
            es = 1'b0;
            ef = 1'b0;
            ep = 1'b0;
            if (!reset) begin
                model_data = 8'h00;
            end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                ev = exp_q.pop_front();
                case (ev.kind)
                    EV_GOOD: begin es = 1'b1; model_data = ev.data; end
                    EV_FERR: ef = 1'b1;
                    default: ep = 1'b1;
                endcase
            end
            check("rx_status", rx_status, es);
            check("frame_err", frame_err, ef);
            check("parity_err", parity_err, ep);
            check("rx_data", rx_data, model_data);
            if (rx_status) begin
                n_status++;
                last_status_cyc = cyc;
                got_q.push_back(rx_data);
            end
            if (frame_err) n_ferr++;
            if (parity_err) n_perr++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, s0, f0, p0;
        logic [7:0] seq [3];
        seq[0] = 8'h0A;
        seq[1] = 8'h35;
        seq[2] = 8'h7C;

        #2 reset = 1'b0;
        checking = 1'b1;
        @(posedge sysclk);
        #1;
        wait_cycles(3);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_status", rx_status, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_parity_err", parity_err, 1'b0);
        check("reset_busy", busy, 1'b0);
        reset = 1'b1;
        wait_cycles(5);

        // Single good byte: data, one strobe, exact latency, back to idle.
        s0 = n_status;
        send_frame(8'h0A, 1'b1, 1'b0, k);
        wait_cycles(10);
        check("first_latency", last_status_cyc - k, PAR_EN ? 171 : 155);
        check("first_data", rx_data, 8'h0A);
        check("first_count", n_status - s0, 1);
        check("first_busy", busy, 1'b0);

        // Three frames with no idle between them.
        s0 = n_status;
        got_q.delete();
        for (int i = 0; i < 3; i++) send_frame(seq[i], 1'b1, ^seq[i], k);
        wait_cycles(10);
        check("b2b_count", n_status - s0, 3);
        for (int i = 0; i < got_q.size() && i < 3; i++) check("b2b_seq", got_q[i], seq[i]);

        // Short low glitch: rejected at the start midpoint.
        s0 = n_status;
        f0 = n_ferr;
        p0 = n_perr;
        uart_rx = 1'b0;
        wait_cycles(4);
        check("glitch_busy_high", busy, 1'b1);
        wait_cycles(1);
        uart_rx = 1'b1;
        for (int i = 0; i < 10 && busy; i++) wait_cycles(1);
        check("glitch_busy_fall", busy, 1'b0);
        wait_cycles(20);
        check("glitch_no_pulse", (n_status - s0) + (n_ferr - f0) + (n_perr - p0), 0);

        // Stop bit low then break: one frame_err, byte held, busy until line high.
        send_frame(8'h0A, 1'b1, 1'b0, k);
        f0 = n_ferr;
        send_frame(8'h55, 1'b0, 1'b0, k);
        wait_cycles(40);
        check("ferr_count", n_ferr - f0, 1);
        check("ferr_data_held", rx_data, 8'h0A);
        check("ferr_busy", busy, 1'b1);
        uart_rx = 1'b1;
        wait_cycles(4);
        check("ferr_busy_release", busy, 1'b0);
        wait_cycles(20);

        // Reset in the middle of a frame discards it.
        s0 = n_status;
        f0 = n_ferr;
        p0 = n_perr;
        uart_rx = 1'b0;
        wait_cycles(40);
        check("midreset_busy_before", busy, 1'b1);
        reset = 1'b0;
        uart_rx = 1'b1;
        wait_cycles(3);
        check("midreset_busy", busy, 1'b0);
        check("midreset_data", rx_data, 8'h00);
        reset = 1'b1;
        wait_cycles(200);
        check("midreset_no_pulse", (n_status - s0) + (n_ferr - f0) + (n_perr - p0), 0);

`ifdef UART_RX_PARITY_EN
        // 0x03 has even weight, so parity bit 1 is a mismatch and 0 is accepted.
        s0 = n_status;
        p0 = n_perr;
        send_frame(8'h03, 1'b1, 1'b1, k);
        wait_cycles(5);
        check("parity_err_count", n_perr - p0, 1);
        check("parity_err_no_status", n_status - s0, 0);
        send_frame(8'h03, 1'b1, 1'b0, k);
        wait_cycles(5);
        check("parity_ok_data", rx_data, 8'h03);
        check("parity_ok_count", n_status - s0, 1);
`endif

        // Randomized traffic: gaps, stop errors with breaks, bad parity, glitches.
        for (int i = 0; i < 40; i++) begin
            logic [7:0] d;
            logic       sb, pb;
            d  = 8'($urandom);
            sb = ($urandom_range(0, 5) != 0);
            pb = (^d) ^ ($urandom_range(0, 3) == 0);
            send_frame(d, sb, pb, k);
            if (!sb) begin
                wait_cycles(int'($urandom_range(0, 30)));
                uart_rx = 1'b1;
                wait_cycles(int'($urandom_range(2, 20)));
            end else begin
                wait_cycles(int'($urandom_range(0, 20)));
            end
            if ($urandom_range(0, 3) == 0) begin
                uart_rx = 1'b0;
                wait_cycles(int'($urandom_range(1, 6)));
                uart_rx = 1'b1;
                wait_cycles(16);
            end
        end

        wait_cycles(200);
        check("all_events_seen", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
